seg_scan_decoder: RTL and testbench

- Receiving end of the multiplexed 7-segment bus driven by the display driver.
- Samples the 12-bit segment/enable bus and recovers the hex value of each of the 4 scanned digits.
- Publishes a 16-bit value once every digit has been seen in a scan frame.
- Used in loopback self-check of the counter/display path and as a bench monitor.

---
 rtl/seg_scan_decoder.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Purpose : recovers the 4 hex digits shown on a multiplexed 7-segment bus and publishes them as one 16-bit frame.
// Latency : segs change to frame_valid is 2 (sync) + STABLE_CYCLES + 1 cycles for the final digit of a frame.
// Backpressure: none; the bus is sampled every cycle, and value/err_mask hold until the next complete frame.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   segs        [11:8] digit enables (active-low, bit 8 = digit0), [7:0] {dp,g,f,e,d,c,b,a} (active-low)
//   value       last complete frame {digit3,digit2,digit1,digit0}
//   frame_valid one-cycle pulse when value/err_mask are updated
//   err_mask    per-digit flag: captured pattern was not a legal hex glyph
//   bus_err     one-cycle pulse when a stable sample has more than one enable low
//
// STABLE_CYCLES must lie in 2..255 and 2**CNT_W must exceed it.

module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] segs,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic [3:0]  err_mask,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] LP_STABLE    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LP_STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);

    // Returns {illegal, hex}; the pattern is active-high gfedcba.
    function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = {1'b0, 4'h0};
            7'h06:   res = {1'b0, 4'h1};
            7'h5B:   res = {1'b0, 4'h2};
            7'h4F:   res = {1'b0, 4'h3};
            7'h66:   res = {1'b0, 4'h4};
            7'h6D:   res = {1'b0, 4'h5};
            7'h7D:   res = {1'b0, 4'h6};
            7'h07:   res = {1'b0, 4'h7};
            7'h7F:   res = {1'b0, 4'h8};
            7'h6F:   res = {1'b0, 4'h9};
            7'h77:   res = {1'b0, 4'hA};
            7'h7C:   res = {1'b0, 4'hB};
            7'h39:   res = {1'b0, 4'hC};
            7'h5E:   res = {1'b0, 4'hD};
            7'h79:   res = {1'b0, 4'hE};
            7'h71:   res = {1'b0, 4'hF};
            default: res = {1'b1, 4'h0};
        endcase
        return res;
    endfunction

    logic [11:0]      r_s1;
    logic [11:0]      r_s2;
    logic [11:0]      r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic [3:0]       r_seen;
    logic [15:0]      r_pend_dig;
    logic [3:0]       r_pend_err;
    logic [15:0]      r_value;
    logic [3:0]       r_err;
    logic             r_fv;
    logic             r_bus_err;

    logic             w_same;
    logic             w_cap;
    logic [3:0]       w_en_low;
    logic             w_one;
    logic             w_multi;
    logic [1:0]       w_idx;
    logic [4:0]       w_glyph;
    logic             w_do_cap;
    logic [15:0]      w_pend_dig_nxt;
    logic [3:0]       w_pend_err_nxt;
    logic [3:0]       w_seen_nxt;
    logic             w_frame_done;

    assign w_same   = (r_s2 == r_s3);
    // Capture on the edge where the counter becomes STABLE_CYCLES, so the
    // captured digit and a completed frame are visible in the same cycle.
    assign w_cap    = w_same && r_armed && (r_cnt == LP_STABLE_M1);
    assign w_en_low = ~r_s2[11:8];
    assign w_glyph  = decode_glyph(~r_s2[6:0]);

    always_comb begin
        w_one   = 1'b0;
        w_multi = 1'b0;
        w_idx   = 2'd0;
        case (w_en_low)
            4'b0000: ;                                  // blank slot between digits
            4'b0001: begin w_one = 1'b1; w_idx = 2'd0; end
            4'b0010: begin w_one = 1'b1; w_idx = 2'd1; end
            4'b0100: begin w_one = 1'b1; w_idx = 2'd2; end
            4'b1000: begin w_one = 1'b1; w_idx = 2'd3; end
            default: w_multi = 1'b1;
        endcase
    end

    always_comb begin
        w_do_cap       = w_cap && w_one;
        w_pend_dig_nxt = r_pend_dig;
        w_pend_err_nxt = r_pend_err;
        w_seen_nxt     = r_seen;
        if (w_do_cap) begin
            w_pend_dig_nxt[{w_idx, 2'b00} +: 4] = w_glyph[3:0];
            w_pend_err_nxt[w_idx]               = w_glyph[4];
            w_seen_nxt[w_idx]                   = 1'b1;
        end
        w_frame_done = w_do_cap && (w_seen_nxt == 4'hF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1       <= 12'hFFF;
            r_s2       <= 12'hFFF;
            r_s3       <= 12'hFFF;
            r_cnt      <= '0;
            r_armed    <= 1'b1;
            r_seen     <= 4'h0;
            r_pend_dig <= 16'h0;
            r_pend_err <= 4'h0;
            r_value    <= 16'h0;
            r_err      <= 4'h0;
            r_fv       <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_s1 <= segs;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (w_same) begin
                if (r_cnt != LP_STABLE) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end
            // Only one capture per stable window, even while the counter sits saturated.
            if (w_cap) begin
                r_armed <= 1'b0;
            end

            r_bus_err  <= w_cap && w_multi;
            r_fv       <= w_frame_done;
            r_pend_dig <= w_pend_dig_nxt;
            r_pend_err <= w_pend_err_nxt;

            if (w_frame_done) begin
                r_value <= w_pend_dig_nxt;
                r_err   <= w_pend_err_nxt;
                r_seen  <= 4'h0;
            end else begin
                r_seen  <= w_seen_nxt;
            end
        end
    end

    assign value       = r_value;
    assign err_mask    = r_err;
    assign frame_valid = r_fv;
    assign bus_err     = r_bus_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Purpose : self-checking bench for seg_scan_decoder using directed vectors.
// Latency : checks the final-digit to frame_valid latency of STABLE_CYCLES+3 cycles.
// Backpressure: not applicable; the bench drives segs freely.

module tb_seg_scan_decoder;

    localparam int S = 4;

    logic        clk;
    logic        reset;
    logic [11:0] segs;
    logic [15:0] value;
    logic        frame_valid;
    logic [3:0]  err_mask;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    int be_cnt   = 0;

    seg_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .segs        (segs),
        .value       (value),
        .frame_valid (frame_valid),
        .err_mask    (err_mask),
        .bus_err     (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters; a pulse longer than one cycle shows up as an extra count.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) fv_cnt <= fv_cnt + 1;
            if (bus_err)     be_cnt <= be_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [11:0] s, input int n);
        @(negedge clk);
        segs = s;
        repeat (n) @(posedge clk);
    endtask

    typedef struct {
        logic [3:0][11:0] s;
        logic [15:0]      exp_value;
        logic [3:0]       exp_err;
        string            name;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int fv0;
        int be0;

        vecs[0] = '{s: '{12'h799, 12'hBB0, 12'hDA4, 12'hEF9}, exp_value: 16'h4321, exp_err: 4'h0, name: "v0_1234"};
        vecs[1] = '{s: '{12'hEC0, 12'hD99, 12'hB82, 12'h7F8}, exp_value: 16'h7640, exp_err: 4'h0, name: "v1_rev_order"};
        vecs[2] = '{s: '{12'h783, 12'hB88, 12'hD90, 12'hE80}, exp_value: 16'hBA98, exp_err: 4'h0, name: "v2_89Ab"};
        vecs[3] = '{s: '{12'h78E, 12'hB86, 12'hDA1, 12'hEC6}, exp_value: 16'hFEDC, exp_err: 4'h0, name: "v3_CdEF"};
        vecs[4] = '{s: '{12'h7B0, 12'hBA4, 12'hDF7, 12'hEFF}, exp_value: 16'h3200, exp_err: 4'h3, name: "v4_illegal"};
        vecs[5] = '{s: '{12'h730, 12'hBA4, 12'hD79, 12'hE12}, exp_value: 16'h3215, exp_err: 4'h0, name: "v5_dp_lit"};

        reset = 1'b1;
        segs  = 12'hFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset and idle hold
        hold(12'hFFF, 50);
        @(negedge clk);
        check("rst_value", 32'(value), 32'h0);
        check("rst_err", 32'(err_mask), 32'h0);
        check("rst_fv_count", 32'(fv_cnt), 32'd0);
        check("rst_be_count", 32'(be_cnt), 32'd0);

        // Single digit, then complete frame with latency check
        hold(12'hE92, 10);
        @(negedge clk);
        check("single_no_frame", 32'(fv_cnt), 32'd0);
        hold(12'hDF9, 10);
        hold(12'hBA4, 10);
        @(negedge clk);
        segs = 12'h7B0;
        repeat (S + 2) @(posedge clk);
        @(negedge clk);
        check("lat_not_early", 32'(frame_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_pulse", 32'(frame_valid), 32'd1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("first_value", 32'(value), 32'h3215);
        check("first_err", 32'(err_mask), 32'h0);
        check("first_fv_count", 32'(fv_cnt), 32'd1);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            fv0 = fv_cnt;
            for (int d = 0; d < 4; d++) hold(vecs[i].s[d], 10);
            @(negedge clk);
            check({vecs[i].name, "_value"}, 32'(value), 32'(vecs[i].exp_value));
            check({vecs[i].name, "_err"}, 32'(err_mask), 32'(vecs[i].exp_err));
            check({vecs[i].name, "_fv"}, 32'(fv_cnt - fv0), 32'd1);
        end

        // Glitch rejection: '5' held one cycle too short, then '1'
        fv0 = fv_cnt;
        hold(12'hE92, S - 1);
        hold(12'hEF9, 10);
        hold(12'hDF9, 10);
        hold(12'hBA4, 10);
        hold(12'h7B0, 10);
        @(negedge clk);
        check("glitch_value", 32'(value), 32'h3211);
        check("glitch_fv", 32'(fv_cnt - fv0), 32'd1);

        // Illegal glyph, then overwrite of the bad digit within a frame
        hold(12'hBFF, 10);
        hold(12'hE92, 10);
        hold(12'hDF9, 10);
        hold(12'h7B0, 10);
        @(negedge clk);
        check("blank_glyph_value", 32'(value), 32'h3015);
        check("blank_glyph_err", 32'(err_mask), 32'h4);
        fv0 = fv_cnt;
        hold(12'hBFF, 10);
        hold(12'hE92, 10);
        hold(12'hBA4, 10);
        hold(12'hDF9, 10);
        hold(12'h7B0, 10);
        @(negedge clk);
        check("overwrite_value", 32'(value), 32'h3215);
        check("overwrite_err", 32'(err_mask), 32'h0);
        check("overwrite_fv", 32'(fv_cnt - fv0), 32'd1);

        // Multiple enables low: bus error, seen mask untouched
        fv0 = fv_cnt;
        be0 = be_cnt;
        hold(12'hE99, 10);
        hold(12'hDF9, 10);
        hold(12'hBA4, 10);
        hold(12'hC92, 10);
        @(negedge clk);
        check("multi_be", 32'(be_cnt - be0), 32'd1);
        check("multi_no_frame", 32'(fv_cnt - fv0), 32'd0);
        hold(12'h7B0, 10);
        @(negedge clk);
        check("multi_seen_kept", 32'(fv_cnt - fv0), 32'd1);
        check("multi_value", 32'(value), 32'h3214);

        // Reset mid-frame discards pending digits
        hold(12'hE80, 10);
        hold(12'hD80, 10);
        hold(12'hB80, 10);
        @(negedge clk);
        segs  = 12'hFFF;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        fv0 = fv_cnt;
        hold(12'hFFF, 10);
        @(negedge clk);
        check("midrst_value", 32'(value), 32'h0);
        hold(12'h7B0, 10);
        @(negedge clk);
        check("midrst_no_frame", 32'(fv_cnt - fv0), 32'd0);
        hold(12'hE92, 10);
        hold(12'hDF9, 10);
        hold(12'hBA4, 10);
        @(negedge clk);
        check("midrst_fv", 32'(fv_cnt - fv0), 32'd1);
        check("midrst_value_new", 32'(value), 32'h3215);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
